// File: rtl/arb4_rr_pkg.sv
// Shared types and the round-robin search used by the four-way arbiter.
// The search starts just after the most recent owner and can skip that owner.
package arb4_rr_pkg;

  localparam int ARB_NUM_REQ = 4;

  typedef logic [ARB_NUM_REQ-1:0] req_vec_t;
  typedef logic [1:0]             owner_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic   found;
    owner_t winner;
  } rr_pick_t;

  // Search order is last+1, last+2, last+3, last (mod 4); first asserted req wins.
  // Walking the order backwards lets the earliest hit overwrite later ones.
  function automatic rr_pick_t rr_search(input req_vec_t req,
                                         input owner_t   last,
                                         input logic     exclude_owner);
    rr_pick_t pick;
    owner_t   idx;
    pick.found  = 1'b0;
    pick.winner = last;
    for (int k = ARB_NUM_REQ; k >= 1; k--) begin
      idx = last + owner_t'(k);
      if (req[idx] && !(exclude_owner && (k == ARB_NUM_REQ))) begin
        pick.found  = 1'b1;
        pick.winner = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/arb4_rr_if.sv
// Requester-side bundle of the arbiter: request vector, four data inputs,
// and the grant/select/status/muxed-data outputs.
interface arb4_rr_if #(
  parameter int BIT_WIDTH = 32
);
  import arb4_rr_pkg::*;

  req_vec_t             i_req;
  logic [BIT_WIDTH-1:0] i_in0;
  logic [BIT_WIDTH-1:0] i_in1;
  logic [BIT_WIDTH-1:0] i_in2;
  logic [BIT_WIDTH-1:0] i_in3;
  req_vec_t             o_grant;
  owner_t               o_select;
  logic                 o_busy;
  logic                 o_timeout;
  logic [BIT_WIDTH-1:0] o_out;

  modport master (
    output i_req, i_in0, i_in1, i_in2, i_in3,
    input  o_grant, o_select, o_busy, o_timeout, o_out
  );

  modport slave (
    input  i_req, i_in0, i_in1, i_in2, i_in3,
    output o_grant, o_select, o_busy, o_timeout, o_out
  );

endinterface

// File: rtl/arb4_rr_mux4to1.sv
// Mux4to1: plain combinational four-way data selector for the shared datapath.
// Clock and reset are carried through the port list but not used by the selector.
module arb4_rr_mux4to1
  import arb4_rr_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  owner_t               i_sel,
  input  logic [BIT_WIDTH-1:0] i_d0,
  input  logic [BIT_WIDTH-1:0] i_d1,
  input  logic [BIT_WIDTH-1:0] i_d2,
  input  logic [BIT_WIDTH-1:0] i_d3,
  output logic [BIT_WIDTH-1:0] o_y
);

  logic w_unused;
  assign w_unused = ^{i_clk, i_reset};

  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

// File: rtl/arb4_rr.sv
// Four-requester round-robin arbiter with an optional hold limit, owning the
// select of the shared data mux.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ARB_IDLE | no owner; grant=0, select keeps the previous owner
//   ARB_OWN  | grant[r_owner]=1; hold counter runs while the owner requests
module arb4_rr
  import arb4_rr_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int MAX_HOLD  = 16
) (
  input logic      i_clk,
  input logic      i_reset,
  arb4_rr_if.slave bus
);

  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic LIMIT_EN = (MAX_HOLD > 0);

  arb_state_t r_state;
  owner_t     r_owner;
  owner_t     r_last;
  cnt_t       r_cnt;

  arb_state_t w_state_nxt;
  owner_t     w_owner_nxt;
  owner_t     w_last_nxt;
  cnt_t       w_cnt_nxt;
  logic       w_timeout;
  logic       w_owner_req;
  logic       w_hold_hit;
  rr_pick_t   w_pick;
  req_vec_t   w_grant;
  logic       w_busy;
  logic [BIT_WIDTH-1:0] w_mux;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ARB_IDLE;
      r_owner <= 2'd0;
      r_last  <= 2'd3;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_owner_req = bus.i_req[r_owner];
  assign w_hold_hit  = LIMIT_EN && (r_cnt == CNT_LAST);
  // While owning, the owner is excluded: on release its req is already low,
  // and on a hold-limit hit it only wins again when nobody else asks.
  assign w_pick      = rr_search(bus.i_req, r_last, r_state == ARB_OWN);

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_timeout   = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick.found) begin
          w_state_nxt = ARB_OWN;
          w_owner_nxt = w_pick.winner;
          w_last_nxt  = w_pick.winner;
          w_cnt_nxt   = '0;
        end
      end
      ARB_OWN: begin
        if (!w_owner_req) begin
          w_cnt_nxt = '0;
          if (w_pick.found) begin
            w_owner_nxt = w_pick.winner;
            w_last_nxt  = w_pick.winner;
          end else begin
            w_state_nxt = ARB_IDLE;
          end
        end else if (w_hold_hit) begin
          w_timeout   = 1'b1;
          w_cnt_nxt   = '0;
          w_owner_nxt = w_pick.found ? w_pick.winner : r_owner;
          w_last_nxt  = w_pick.found ? w_pick.winner : r_owner;
        end else if (r_cnt != {CNT_W{1'b1}}) begin
          w_cnt_nxt = r_cnt + cnt_t'(1);
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    w_grant = '0;
    if (r_state == ARB_OWN) w_grant[r_owner] = 1'b1;
  end

  assign w_busy = (r_state == ARB_OWN);

  arb4_rr_mux4to1 #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_mux (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sel   (r_owner),
    .i_d0    (bus.i_in0),
    .i_d1    (bus.i_in1),
    .i_d2    (bus.i_in2),
    .i_d3    (bus.i_in3),
    .o_y     (w_mux)
  );

  assign bus.o_grant   = w_grant;
  assign bus.o_select  = r_owner;
  assign bus.o_busy    = w_busy;
  assign bus.o_timeout = w_timeout;
  assign bus.o_out     = w_mux & {BIT_WIDTH{w_busy}};

endmodule

// File: tb/tb_arb4_rr.sv
// Bench for arb4_rr: one instance with a hold limit of 4 and one with no limit,
// checked every cycle against an ownership-level model plus directed literals.
module tb_arb4_rr;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [31:0] din [4] = '{32'h0, 32'h0, 32'h0, 32'h0};

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  arb4_rr_if #(.BIT_WIDTH(32)) if_a ();
  arb4_rr_if #(.BIT_WIDTH(32)) if_b ();

  assign if_a.i_req = req;
  assign if_a.i_in0 = din[0];
  assign if_a.i_in1 = din[1];
  assign if_a.i_in2 = din[2];
  assign if_a.i_in3 = din[3];
  assign if_b.i_req = req;
  assign if_b.i_in0 = din[0];
  assign if_b.i_in1 = din[1];
  assign if_b.i_in2 = din[2];
  assign if_b.i_in3 = din[3];

  arb4_rr #(.BIT_WIDTH(32), .MAX_HOLD(4)) u_dut_a (.i_clk(clk), .i_reset(reset), .bus(if_a));
  arb4_rr #(.BIT_WIDTH(32), .MAX_HOLD(0)) u_dut_b (.i_clk(clk), .i_reset(reset), .bus(if_b));

  // Model: owner index (-1 idle), previous owner, displayed select, cycles held so far.
  int m_owner [2] = '{-1, -1};
  int m_last  [2] = '{3, 3};
  int m_sel   [2] = '{0, 0};
  int m_held  [2] = '{0, 0};
  int m_lim   [2] = '{4, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last, input bit skip_last);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (r[c] && !(k == 4 && skip_last)) return c;
    end
    return -1;
  endfunction

  task automatic grant_to(input int d, input int w);
    m_owner[d] = w;
    m_last[d]  = w;
    m_sel[d]   = w;
    m_held[d]  = 1;
  endtask

  task automatic model_step(input int d);
    int w;
    if (reset) begin
      m_owner[d] = -1; m_last[d] = 3; m_sel[d] = 0; m_held[d] = 0;
    end else if (m_owner[d] < 0) begin
      w = rr_pick(req, m_last[d], 1'b0);
      if (w >= 0) grant_to(d, w);
    end else if (!req[m_owner[d]]) begin
      w = rr_pick(req, m_last[d], 1'b1);
      if (w >= 0) grant_to(d, w);
      else m_owner[d] = -1;
    end else if (m_lim[d] > 0 && m_held[d] == m_lim[d]) begin
      w = rr_pick(req, m_last[d], 1'b1);
      grant_to(d, (w >= 0) ? w : m_owner[d]);
    end else begin
      m_held[d]++;
    end
  endtask

  task automatic cmp_dut(input int d, input logic [3:0] g, input logic [1:0] s,
                         input logic b, input logic t, input logic [31:0] o);
    logic [3:0]  eg;
    logic        eb;
    logic        et;
    logic [31:0] eo;
    eb = (m_owner[d] >= 0);
    eg = eb ? (4'b0001 << m_owner[d]) : 4'b0000;
    et = eb && req[m_owner[d]] && (m_lim[d] > 0) && (m_held[d] == m_lim[d]);
    eo = eb ? din[m_sel[d]] : 32'h0;
    check($sformatf("dut%0d grant", d),   {28'h0, g}, {28'h0, eg});
    check($sformatf("dut%0d select", d),  {30'h0, s}, 32'(m_sel[d]));
    check($sformatf("dut%0d busy", d),    {31'h0, b}, {31'h0, eb});
    check($sformatf("dut%0d timeout", d), {31'h0, t}, {31'h0, et});
    check($sformatf("dut%0d out", d),     o, eo);
  endtask

  initial forever begin
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_step(d);
    if (reset) chk_en = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp_dut(0, if_a.o_grant, if_a.o_select, if_a.o_busy, if_a.o_timeout, if_a.o_out);
      cmp_dut(1, if_b.o_grant, if_b.o_select, if_b.o_busy, if_b.o_timeout, if_b.o_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] g;

    // Idle after reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("idle grant", {28'h0, if_a.o_grant}, 32'h0);
      check("idle busy", {31'h0, if_a.o_busy}, 32'h0);
      check("idle out", if_a.o_out, 32'h0);
    end

    // Single requester 2
    din[2] = 32'hDEADBEEF;
    req = 4'b0100;
    tick();
    @(negedge clk);
    check("req2 grant", {28'h0, if_a.o_grant}, 32'h4);
    check("req2 select", {30'h0, if_a.o_select}, 32'h2);
    check("req2 out", if_a.o_out, 32'hDEADBEEF);
    tick();
    req = 4'b0000;
    tick();
    @(negedge clk);
    check("req2 drop grant", {28'h0, if_a.o_grant}, 32'h0);
    check("req2 drop out", if_a.o_out, 32'h0);

    // All requesting, each owner releases after two cycles
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      g = 4'b0001 << (i % 4);
      tick();
      req = 4'b1111;
      @(negedge clk);
      check("rr first cycle", {28'h0, if_a.o_grant}, {28'h0, g});
      tick();
      req = 4'b1111 & ~g;
      @(negedge clk);
      check("rr second cycle", {28'h0, if_a.o_grant}, {28'h0, g});
    end

    // Hold limit with two contenders
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 9; i++) begin
      tick();
      @(negedge clk);
      g = (i < 4) ? 4'b0001 : (i < 8) ? 4'b0010 : 4'b0001;
      check("hold4 grant", {28'h0, if_a.o_grant}, {28'h0, g});
      check("hold4 timeout", {31'h0, if_a.o_timeout}, (i == 3 || i == 7) ? 32'h1 : 32'h0);
      check("nolimit grant", {28'h0, if_b.o_grant}, 32'h1);
      check("nolimit timeout", {31'h0, if_b.o_timeout}, 32'h0);
    end

    // Hold limit with a lone requester
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk);
      check("lone grant", {28'h0, if_a.o_grant}, 32'h8);
      check("lone timeout", {31'h0, if_a.o_timeout}, (i % 4 == 3) ? 32'h1 : 32'h0);
    end

    // Reset mid-transfer
    do_reset();
    req = 4'b0010;
    tick();
    @(negedge clk);
    check("pre-reset grant", {28'h0, if_a.o_grant}, 32'h2);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("in-reset grant", {28'h0, if_a.o_grant}, 32'h0);
    check("in-reset select", {30'h0, if_a.o_select}, 32'h0);
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("post-reset grant", {28'h0, if_a.o_grant}, 32'h2);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
        din[b] = $urandom;
      end
      reset = ($urandom_range(0, 299) == 0);
    end
    reset = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arb4_rr.md
# arb4_rr

Round-robin arbiter that shares one BIT_WIDTH-wide datapath resource between four requesters. It owns the select input of a Mux4to1 instance and drives that select from a registered grant. The block sits in front of the shared bus/memory port so that any of four units (fetch, load/store, DMA, debug) can take exclusive ownership, hold it for a multi-cycle transfer, and release it. An optional hold limit prevents one requester from starving the others.

## Interface
- BIT_WIDTH, 32, width of each data input and of the muxed output
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant; 0 disables the limit
- clk  input  1  rising-edge clock; all state updates on this edge only
- reset  input  1  synchronous, active-high reset
- req  input  4  req[i] high = requester i wants, or continues to hold, ownership
- in0, in1, in2, in3  input  BIT_WIDTH  requester data/address, muxed onto out
- grant  output  4  one-hot registered grant; all-zero when idle
- select  output  2  encoded owner index, drives the Mux4to1 select
- busy  output  1  high while any grant is asserted (equals |grant)
- timeout  output  1  one-cycle pulse in the cycle the hold limit forces a handover
- out  output  BIT_WIDTH  in[select] while busy, all zeros while idle

## Operation
- States: IDLE (no owner) and OWN (grant[owner]=1).
- Pointer `last` (2 bits) = most recent owner. Search order for each decision: last+1, last+2, last+3, last, all mod 4. The first asserted req wins.
- IDLE:
  - If any req, the next state is OWN with the winner as owner.
  - Otherwise stay in IDLE.
- OWN, owner still requesting and hold limit not reached:
  - Stay in OWN.
  - Hold counter increments.
- OWN, owner drops req (release):
  - Arbitrate the same cycle; the owner's req is 0, so it is excluded.
  - If any req, the next state is OWN with the new owner, with no idle bubble.
  - Otherwise go to IDLE.
- OWN, hold counter == MAX_HOLD-1 and owner still requesting (MAX_HOLD≠0):
  - Pulse timeout.
  - Arbitrate with the owner last in order.
  - If another req exists, hand over to it.
  - Otherwise the owner is re-granted and the counter restarts.
- Hold counter:
  - Width $clog2(MAX_HOLD+1), minimum 1.
  - Clears on every new grant, including a re-grant.
  - Saturates when MAX_HOLD=0.
- `last` updates to the new owner on every grant.
- select holds its last value while IDLE. out is forced to zero by busy.
- Reset values:
  - grant=0, busy=0, select=0, timeout=0, out=0.
  - last=3, so requester 0 is searched first.
  - Hold counter=0, state IDLE.
- Reset mid-transfer drops the grant in the next cycle, regardless of req.

## Timing
- Grant latency: req rising in cycle N (sampled at edge N+1) produces grant at N+1, one cycle after req.
- Release: owner req low at edge N+1 produces the new grant, or all-zero, at N+1. There is never a cycle with two grant bits set.
- Handover is registered, so an outgoing owner sees grant deassert the same edge the incoming owner sees grant assert.
- With MAX_HOLD=K, a continuously requesting owner holds grant for exactly K cycles before a forced handover, provided another req is pending.
- out is combinational from grant/select and the in* inputs: zero added latency relative to grant.
- Simultaneous requests in IDLE: the winner follows the search order from last+1.
- A req asserted and dropped within the same cycle as a handover decision is honoured only if high at the sampling edge.

## Structure
- Shared package holds:
  - typedef req_vec_t (4-bit)
  - typedef owner_t (2-bit)
  - state enum {ARB_IDLE, ARB_OWN}
  - constant ARB_NUM_REQ=4
- One sub-module: Mux4to1, instantiated with BIT_WIDTH passed through, clk/reset tied through, select driven from the registered owner. Its output is ANDed with busy.
- Round-robin search is a combinational function in the package: (req, last, exclude_owner) -> {found, winner}.

## Test plan
- Reset then req=4'b0000 for 5 cycles -> grant=0, busy=0, out=0 every cycle.
- After reset, req=4'b1111 held, owners release after 2 cycles each -> grants 0,1,2,3,0 in order, each one-hot, no idle cycle between.
- req[2] only, in2=32'hDEADBEEF -> grant=4'b0100 one cycle after req, select=2, out=32'hDEADBEEF. Drop req[2] -> next cycle grant=0, out=0.
- MAX_HOLD=4, req[0] and req[1] held constantly -> grant[0] for 4 cycles, timeout pulse, grant[1] for 4 cycles, timeout, back to 0.
- MAX_HOLD=4, only req[3] held -> timeout every 4th cycle, grant stays 4'b1000 with no gap.
- Reset asserted while grant=4'b0010 with req held -> next cycle grant=0, select=0. After reset release, grant[1] is re-acquired one cycle later.
